lcd_sequencer: RTL and testbench
================================

# lcd_sequencer

Character-LCD (HD44780-compatible, 8-bit bus, write-only) controller for the DE2 front panel. It runs the power-up initialisation, then accepts one character or command at a time over a ready/request handshake. It generates the RS/EN/DATA bus timing and tracks the cursor, inserting the line-change command automatically at the end of each 16-column line. It sits between the keyboard/switch handling in the control unit and the LCD pins, replacing ad-hoc driving of `LCD_DATA`/`LCD_RS` from button edges.

## Interface
Parameters:
- `T_PWR`, 750000: power-up wait in cycles (15 ms at 50 MHz).
- `T_SETUP`, 2: RS/DATA setup time before EN rises.
- `T_EN`, 12: EN high width.
- `T_HOLD`, 2: EN low with DATA held, before the wait phase.
- `T_SHORT`, 2000: post-write wait for ordinary commands and data (40 µs).
- `T_LONG`, 82000: post-write wait for clear (0x01) and home (0x02/0x03) (1.64 ms).

Ports:
- `CLOCK_50`, in, 1: the single clock.
- `reset`, in, 1: synchronous, active-high.
- `req`, in, 1: write request; sampled only when `ready`=1.
- `rs_in`, in, 1: 1 = character data, 0 = command.
- `data_in`, in, 8: byte to write.
- `ready`, out, 1: able to accept a request.
- `init_done`, out, 1: initialisation complete; stays 1 until reset.
- `cursor_line`, out, 1: tracked DDRAM line.
- `cursor_col`, out, 4: tracked column, 0–15.
- `LCD_DATA`, out, 8: LCD data bus.
- `LCD_RS`, out, 1: LCD register select.
- `LCD_RW`, out, 1: read/write select; constant 0.
- `LCD_EN`, out, 1: LCD enable strobe.
- `LCD_ON`, out, 1: panel power; constant 1.
- `LCD_BLON`, out, 1: backlight; constant 1.

## Operation
- Reset values:
  - `ready`, `init_done`, `LCD_EN`, `LCD_RS`, `LCD_RW` = 0.
  - `LCD_DATA` = 0x00.
  - `cursor_line`/`cursor_col` = 0.
  - `LCD_ON`/`LCD_BLON` = 1.
  - State = PWR_WAIT.
- States: PWR_WAIT, INIT, IDLE, SETUP, PULSE, HOLD, WAIT, WRAP.
- A single down-counter, 20 bits minimum, times every state. It is loaded on state entry.
- PWR_WAIT: hold `T_PWR` cycles, then go to INIT.
- INIT: issue the fixed sequence 0x38, 0x0C, 0x01, 0x06, 0x80, all with RS=0. Each command runs a full SETUP→PULSE→HOLD→WAIT cycle. After the last wait: `init_done`=1, `ready`=1, go to IDLE.
- Handshake:
  - Accept occurs at the edge where `req`&&`ready`.
  - At that edge, `rs_in`/`data_in` are latched onto `LCD_RS`/`LCD_DATA`, `ready` goes to 0, and the state moves to SETUP.
  - `req` while `ready`=0 is ignored; there is no queuing.
  - `req` held high is accepted once per `ready` window.
- Write cycle: SETUP (`T_SETUP`, EN=0) → PULSE (`T_EN`, EN=1) → HOLD (`T_HOLD`, EN=0) → WAIT.
- `LCD_DATA`/`LCD_RS` are stable from accept until WAIT exits.
- WAIT length:
  - `T_LONG` if RS=0 and data ∈ {0x01, 0x02, 0x03}.
  - Otherwise `T_SHORT`.
- Cursor tracking, updated at WAIT exit:
  - Data write: `cursor_col`+1.
  - Command 0x01–0x03: line=0, col=0.
  - Command with bit7=1 (set DDRAM address): line=data[6], col=data[3:0]; data[5:4] are ignored.
  - All other commands leave the cursor unchanged.
- WRAP rule: a data write that leaves col=15 does not raise `ready`.
  - The sequencer enters WRAP and issues command 0xC0 (line 0→1) or 0x80 (line 1→0) through a full cycle with `T_SHORT`.
  - The cursor becomes (other line, col 0), then `ready`=1.
- `reset` in any state, including mid-PULSE: every output takes its reset value at that edge and the sequence restarts from PWR_WAIT.

## Timing
- Accept at edge k:
  - `LCD_EN` rises at edge k+`T_SETUP` and falls at edge k+`T_SETUP`+`T_EN`.
  - `ready` rises at edge k+`T_SETUP`+`T_EN`+`T_HOLD`+wait.
- Single-write busy time: `T_SETUP`+`T_EN`+`T_HOLD`+wait cycles.
- A wrapping write adds a second busy period of `T_SETUP`+`T_EN`+`T_HOLD`+`T_SHORT`.
- Init length: `T_PWR` + 5×(`T_SETUP`+`T_EN`+`T_HOLD`) + 4×`T_SHORT` + `T_LONG`.
- `ready` and `init_done` rise on the same edge.
- Cursor outputs update on the same edge that `ready` rises.

## Test plan
All scenarios use `T_PWR`=50, `T_SETUP`=2, `T_EN`=4, `T_HOLD`=2, `T_SHORT`=10, `T_LONG`=40.
- Release reset → no EN for 50 cycles; five EN pulses with RS=0 and DATA 0x38, 0x0C, 0x01, 0x06, 0x80; 40-cycle gap after 0x01; `ready`=`init_done`=1 exactly 170 cycles after reset deasserts.
- Write rs=1, 0x61 → EN high for cycles 2–5 after accept, DATA=0x61, RS=1 throughout; `ready` back at +18; cursor col 0→1.
- Sixteen data writes from (0,0) → after the 16th, an extra EN pulse with RS=0, DATA=0xC0; cursor (1,0); `ready` at +36. Sixteen more writes → 0x80 inserted; cursor (0,0).
- Command 0x01 from cursor (1,7) → `ready` at +48; cursor (0,0). Command 0xC5 → `ready` at +18; cursor (1,5).
- `req` pulsed during busy → ignored, single EN pulse. `req` held high → one accept per `ready` window, with `ready` low for exactly 18 cycles each time.
- Assert `reset` during PULSE → EN=0 and `ready`=0 on the next edge; full init sequence replays.

Source files
------------

// File: rtl/lcd_sequencer.sv
// HD44780 8-bit write-only LCD controller: power-up init, req/ready write
// handshake, RS/EN/DATA bus timing and cursor tracking with automatic line wrap.
module lcd_sequencer #(
  parameter int unsigned T_PWR   = 750000,
  parameter int unsigned T_SETUP = 2,
  parameter int unsigned T_EN    = 12,
  parameter int unsigned T_HOLD  = 2,
  parameter int unsigned T_SHORT = 2000,
  parameter int unsigned T_LONG  = 82000
) (
  input  logic       CLOCK_50,
  input  logic       reset,
  input  logic       req,
  input  logic       rs_in,
  input  logic [7:0] data_in,
  output logic       ready,
  output logic       init_done,
  output logic       cursor_line,
  output logic [3:0] cursor_col,
  output logic [7:0] LCD_DATA,
  output logic       LCD_RS,
  output logic       LCD_RW,
  output logic       LCD_EN,
  output logic       LCD_ON,
  output logic       LCD_BLON
);

  localparam int unsigned T_MAX_A = (T_PWR > T_LONG) ? T_PWR : T_LONG;
  localparam int unsigned T_MAX_B = (T_MAX_A > T_SHORT) ? T_MAX_A : T_SHORT;
  localparam int unsigned T_MAX   = (T_MAX_B > T_EN) ? T_MAX_B : T_EN;
  localparam int unsigned CNT_W   = ($clog2(T_MAX) > 20) ? $clog2(T_MAX) : 20;
  localparam int unsigned IDX_W   = 3;
  localparam logic [IDX_W-1:0] INIT_LAST = IDX_W'(4);

  typedef enum logic [2:0] {
    PWR_WAIT, INIT, IDLE, SETUP, PULSE, HOLD, WAIT, WRAP
  } state_e;

  state_e           state_q, state_d;
  logic [CNT_W-1:0] cnt_q, cnt_d;
  logic [IDX_W-1:0] idx_q, idx_d;
  logic             ready_q, ready_d;
  logic             init_done_q, init_done_d;
  logic             line_q, line_d;
  logic [3:0]       col_q, col_d;
  logic [7:0]       data_q, data_d;
  logic             rs_q, rs_d;
  logic             en_q, en_d;

  logic cnt_done;
  logic long_wait;
  logic wrap_now;

  // Fixed power-up command sequence: 8-bit/2-line, display on, clear, entry mode, home address.
  function automatic logic [7:0] init_cmd(input logic [IDX_W-1:0] idx);
    logic [7:0] cmd;
    unique case (idx)
      IDX_W'(0): cmd = 8'h38;
      IDX_W'(1): cmd = 8'h0C;
      IDX_W'(2): cmd = 8'h01;
      IDX_W'(3): cmd = 8'h06;
      default:   cmd = 8'h80;
    endcase
    return cmd;
  endfunction

  always_ff @(posedge CLOCK_50) begin
    if (reset) begin
      state_q     <= PWR_WAIT;
      cnt_q       <= CNT_W'(T_PWR - 1);
      idx_q       <= '0;
      ready_q     <= 1'b0;
      init_done_q <= 1'b0;
      line_q      <= 1'b0;
      col_q       <= '0;
      data_q      <= 8'h00;
      rs_q        <= 1'b0;
      en_q        <= 1'b0;
    end else begin
      state_q     <= state_d;
      cnt_q       <= cnt_d;
      idx_q       <= idx_d;
      ready_q     <= ready_d;
      init_done_q <= init_done_d;
      line_q      <= line_d;
      col_q       <= col_d;
      data_q      <= data_d;
      rs_q        <= rs_d;
      en_q        <= en_d;
    end
  end

  assign cnt_done  = (cnt_q == '0);
  assign long_wait = !rs_q && (data_q inside {8'h01, 8'h02, 8'h03});
  // A data write issued at the last column is followed by an inserted line-change command.
  assign wrap_now  = init_done_q && rs_q && (col_q == 4'hF);

  always_comb begin
    state_d     = state_q;
    cnt_d       = cnt_done ? cnt_q : cnt_q - CNT_W'(1);
    idx_d       = idx_q;
    ready_d     = ready_q;
    init_done_d = init_done_q;
    line_d      = line_q;
    col_d       = col_q;
    data_d      = data_q;
    rs_d        = rs_q;
    en_d        = en_q;

    unique case (state_q)
      PWR_WAIT: begin
        if (cnt_done) begin
          state_d = INIT;
          cnt_d   = CNT_W'(T_SETUP - 1);
          idx_d   = '0;
          data_d  = init_cmd('0);
          rs_d    = 1'b0;
        end
      end

      IDLE: begin
        if (req && ready_q) begin
          state_d = SETUP;
          cnt_d   = CNT_W'(T_SETUP - 1);
          data_d  = data_in;
          rs_d    = rs_in;
          ready_d = 1'b0;
        end
      end

      INIT, SETUP, WRAP: begin
        if (cnt_done) begin
          state_d = PULSE;
          cnt_d   = CNT_W'(T_EN - 1);
          en_d    = 1'b1;
        end
      end

      PULSE: begin
        if (cnt_done) begin
          state_d = HOLD;
          cnt_d   = CNT_W'(T_HOLD - 1);
          en_d    = 1'b0;
        end
      end

      HOLD: begin
        if (cnt_done) begin
          state_d = WAIT;
          cnt_d   = long_wait ? CNT_W'(T_LONG - 1) : CNT_W'(T_SHORT - 1);
        end
      end

      WAIT: begin
        if (cnt_done) begin
          if (!wrap_now) begin
            if (rs_q) begin
              col_d = col_q + 4'd1;
            end else if (long_wait) begin
              line_d = 1'b0;
              col_d  = '0;
            end else if (data_q[7]) begin
              line_d = data_q[6];
              col_d  = data_q[3:0];
            end
          end

          if (!init_done_q && (idx_q != INIT_LAST)) begin
            state_d = INIT;
            cnt_d   = CNT_W'(T_SETUP - 1);
            idx_d   = idx_q + IDX_W'(1);
            data_d  = init_cmd(idx_q + IDX_W'(1));
            rs_d    = 1'b0;
          end else if (wrap_now) begin
            state_d = WRAP;
            cnt_d   = CNT_W'(T_SETUP - 1);
            data_d  = line_q ? 8'h80 : 8'hC0;
            rs_d    = 1'b0;
          end else begin
            state_d     = IDLE;
            ready_d     = 1'b1;
            init_done_d = 1'b1;
          end
        end
      end

      default: state_d = PWR_WAIT;
    endcase
  end

  assign ready       = ready_q;
  assign init_done   = init_done_q;
  assign cursor_line = line_q;
  assign cursor_col  = col_q;
  assign LCD_DATA    = data_q;
  assign LCD_RS      = rs_q;
  assign LCD_EN      = en_q;
  assign LCD_RW      = 1'b0;
  assign LCD_ON      = 1'b1;
  assign LCD_BLON    = 1'b1;

endmodule

// File: tb/tb_lcd_sequencer.sv
// Scoreboard bench for lcd_sequencer: a cursor/timing reference model pushes expected
// EN pulses and ready events; a negedge monitor pops and compares them.
module tb_lcd_sequencer;

  localparam int T_PWR   = 50;
  localparam int T_SETUP = 2;
  localparam int T_EN    = 4;
  localparam int T_HOLD  = 2;
  localparam int T_SHORT = 10;
  localparam int T_LONG  = 40;
  localparam int T_CYC   = T_SETUP + T_EN + T_HOLD;

  typedef struct {
    logic       rs;
    logic [7:0] data;
    int         rise;
  } pulse_t;

  typedef struct {
    int         busy;
    logic       line;
    logic [3:0] col;
  } rdy_t;

  logic       CLOCK_50 = 1'b0;
  logic       reset    = 1'b1;
  logic       req      = 1'b0;
  logic       rs_in    = 1'b0;
  logic [7:0] data_in  = 8'h00;
  logic       ready, init_done, cursor_line;
  logic [3:0] cursor_col;
  logic [7:0] LCD_DATA;
  logic       LCD_RS, LCD_RW, LCD_EN, LCD_ON, LCD_BLON;

  lcd_sequencer #(
    .T_PWR(T_PWR), .T_SETUP(T_SETUP), .T_EN(T_EN),
    .T_HOLD(T_HOLD), .T_SHORT(T_SHORT), .T_LONG(T_LONG)
  ) dut (
    .CLOCK_50(CLOCK_50), .reset(reset), .req(req), .rs_in(rs_in), .data_in(data_in),
    .ready(ready), .init_done(init_done), .cursor_line(cursor_line), .cursor_col(cursor_col),
    .LCD_DATA(LCD_DATA), .LCD_RS(LCD_RS), .LCD_RW(LCD_RW), .LCD_EN(LCD_EN),
    .LCD_ON(LCD_ON), .LCD_BLON(LCD_BLON)
  );

  always #5 CLOCK_50 = ~CLOCK_50;

  int cyc = 0;
  always @(posedge CLOCK_50) cyc <= cyc + 1;

  int checks   = 0;
  int failures = 0;

  pulse_t exp_pulse_q[$];
  rdy_t   exp_rdy_q[$];
  logic       m_line = 1'b0;
  logic [3:0] m_col  = 4'd0;

  task automatic chk(input string name, input longint act, input longint exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s: got %0d (0x%0h), expected %0d (0x%0h) at cycle %0d",
               name, act, act, exp, exp, cyc);
    end
  endtask

  task automatic flag(input string name, input string what);
    checks++;
    failures++;
    $display("FAIL %s: %s at cycle %0d", name, what, cyc);
  endtask

  function automatic int wait_of(input logic rs, input logic [7:0] d);
    return (!rs && d >= 8'h01 && d <= 8'h03) ? T_LONG : T_SHORT;
  endfunction

  // Reference model: expected pulses (rise offset from the start edge) and ready event.
  task automatic model_write(input logic rs, input logic [7:0] d);
    int     t;
    pulse_t p;
    rdy_t   r;
    t = 0;
    p.rs = rs; p.data = d; p.rise = t + T_SETUP;
    exp_pulse_q.push_back(p);
    t += T_CYC + wait_of(rs, d);
    if (rs) begin
      if (m_col == 4'd15) begin
        p.rs = 1'b0; p.data = m_line ? 8'h80 : 8'hC0; p.rise = t + T_SETUP;
        exp_pulse_q.push_back(p);
        t += T_CYC + T_SHORT;
        m_line = !m_line;
        m_col  = 4'd0;
      end else begin
        m_col = m_col + 4'd1;
      end
    end else if (d >= 8'h01 && d <= 8'h03) begin
      m_line = 1'b0;
      m_col  = 4'd0;
    end else if (d[7]) begin
      m_line = d[6];
      m_col  = d[3:0];
    end
    r.busy = t; r.line = m_line; r.col = m_col;
    exp_rdy_q.push_back(r);
  endtask

  task automatic model_init();
    logic [7:0] cmds [5];
    int         t;
    pulse_t     p;
    rdy_t       r;
    cmds = '{8'h38, 8'h0C, 8'h01, 8'h06, 8'h80};
    t = T_PWR;
    for (int i = 0; i < 5; i++) begin
      p.rs = 1'b0; p.data = cmds[i]; p.rise = t + T_SETUP;
      exp_pulse_q.push_back(p);
      t += T_CYC + wait_of(1'b0, cmds[i]);
    end
    r.busy = t; r.line = 1'b0; r.col = 4'd0;
    exp_rdy_q.push_back(r);
  endtask

  // Monitor: runs on the falling edge, away from the active edge.
  int     start = 0, rise_cyc = 0, rise_start = -1;
  logic   prev_en = 1'b0, prev_ready = 1'b0, cur_valid = 1'b0;
  pulse_t cur;
  rdy_t   rr;

  always @(negedge CLOCK_50) begin
    if (LCD_EN === 1'b1 && prev_en !== 1'b1) begin
      if (exp_pulse_q.size() == 0) begin
        flag("unexpected_en_pulse", "EN rose with no pulse expected");
        cur_valid = 1'b0;
      end else begin
        cur = exp_pulse_q.pop_front();
        cur_valid = 1'b1;
        chk("en_rise_offset", cyc - start, cur.rise);
        chk("pulse_rs", LCD_RS, cur.rs);
        chk("pulse_data", LCD_DATA, cur.data);
        rise_cyc   = cyc;
        rise_start = start;
      end
    end else if (LCD_EN === 1'b1 && cur_valid) begin
      chk("rs_stable_in_pulse", LCD_RS, cur.rs);
      chk("data_stable_in_pulse", LCD_DATA, cur.data);
    end
    if (LCD_EN === 1'b0 && prev_en === 1'b1 && rise_start == start)
      chk("en_width", cyc - rise_cyc, T_EN);

    if (ready === 1'b1 && prev_ready !== 1'b1) begin
      if (exp_rdy_q.size() == 0) begin
        flag("unexpected_ready", "ready rose with no write outstanding");
      end else begin
        rr = exp_rdy_q.pop_front();
        chk("busy_cycles", cyc - start, rr.busy);
        chk("cursor_line", cursor_line, rr.line);
        chk("cursor_col", cursor_col, rr.col);
        chk("init_done_at_ready", init_done, 1);
      end
    end

    if (reset === 1'b1) start = cyc + 1;
    else if (ready === 1'b1 && req === 1'b1) start = cyc + 1;
    prev_en    = LCD_EN;
    prev_ready = ready;
  end

  task automatic apply_reset(input int n);
    reset = 1'b1;
    req   = 1'b0;
    repeat (n) begin @(posedge CLOCK_50); #1; end
    exp_pulse_q.delete();
    exp_rdy_q.delete();
    m_line = 1'b0;
    m_col  = 4'd0;
    chk("rst_ready", ready, 0);
    chk("rst_init_done", init_done, 0);
    chk("rst_en", LCD_EN, 0);
    chk("rst_rs", LCD_RS, 0);
    chk("rst_rw", LCD_RW, 0);
    chk("rst_data", LCD_DATA, 0);
    chk("rst_line", cursor_line, 0);
    chk("rst_col", cursor_col, 0);
    chk("rst_lcd_on", LCD_ON, 1);
    chk("rst_blon", LCD_BLON, 1);
    reset = 1'b0;
    model_init();
  endtask

  task automatic wait_ready();
    int n;
    n = 0;
    while (ready !== 1'b1 && n < 2000) begin
      @(posedge CLOCK_50); #1;
      n++;
    end
    if (ready !== 1'b1) flag("ready_timeout", "ready still 0 after 2000 cycles, expected 1");
  endtask

  task automatic write(input logic rs, input logic [7:0] d, input bit hold);
    wait_ready();
    rs_in   = rs;
    data_in = d;
    req     = 1'b1;
    model_write(rs, d);
    @(posedge CLOCK_50); #1;
    if (!hold) req = 1'b0;
  endtask

  initial begin
    int n;
    apply_reset(3);

    write(1'b1, 8'h61, 1'b0);
    write(1'b0, 8'h80, 1'b0);
    for (int i = 0; i < 32; i++) write(1'b1, 8'h41 + 8'(i % 26), 1'b0);

    write(1'b0, 8'hC7, 1'b0);
    write(1'b0, 8'h01, 1'b0);
    write(1'b0, 8'hC5, 1'b0);
    write(1'b0, 8'h02, 1'b0);
    write(1'b0, 8'hBF, 1'b0);

    // Request during busy must be dropped.
    write(1'b1, 8'h42, 1'b0);
    rs_in = 1'b0; data_in = 8'h01; req = 1'b1;
    @(posedge CLOCK_50); #1;
    req = 1'b0;
    repeat (3) begin @(posedge CLOCK_50); #1; end
    rs_in = 1'b1; data_in = 8'h7A; req = 1'b1;
    @(posedge CLOCK_50); #1;
    req = 1'b0;

    // Request held high: one accept per ready window.
    for (int i = 0; i < 3; i++) write(1'b0, 8'h0C, 1'b1);
    req = 1'b0;

    for (int i = 0; i < 40; i++) begin
      logic       rs;
      logic [7:0] d;
      rs = ($urandom_range(0, 3) != 0);
      d  = 8'($urandom_range(0, 255));
      write(rs, d, 1'b0);
      repeat ($urandom_range(0, 3)) begin @(posedge CLOCK_50); #1; end
    end

    // Reset in the middle of an EN pulse, then the full init replays.
    write(1'b1, 8'h55, 1'b0);
    n = 0;
    while (LCD_EN !== 1'b1 && n < 100) begin @(posedge CLOCK_50); #1; n++; end
    if (LCD_EN !== 1'b1) flag("en_timeout", "EN never rose after accept");
    apply_reset(1);
    write(1'b1, 8'h5A, 1'b0);
    write(1'b0, 8'hCF, 1'b0);
    write(1'b1, 8'h21, 1'b0);

    wait_ready();
    repeat (4) begin @(posedge CLOCK_50); #1; end
    chk("leftover_pulses", exp_pulse_q.size(), 0);
    chk("leftover_ready_events", exp_rdy_q.size(), 0);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
